// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: capture sequencer for the 32-bit filter-data block RAM.
// Writes a strobed sample stream into consecutive RAM addresses (IDLE/CAPTURE/DONE),
// then serves single-word readout requests from the CPU side.
// Optional feature macro: CIRCULAR_CAPTURE_EN (write pointer wraps, capture runs until stop).
// o_count saturates at DEPTH; DEPTH is assumed to be representable in ADDR_WIDTH bits.
module bram_capture_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32000,
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  rstb,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_sample_valid,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_err,
  output logic                  o_rd_busy,
  output logic                  o_busy,
  output logic                  o_full,
  output logic [ADDR_WIDTH-1:0] o_count,
  output logic [ADDR_WIDTH-1:0] o_wr_ptr,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_COUNT = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_WIDE  = (ADDR_WIDTH + 1)'(DEPTH);

  state_t state;
  state_t state_next;

  logic start_acc;
  logic wr_acc;
  logic at_last;
  logic rd_acc;
  logic rd_oob;
  logic ram_ready;

  logic [RAM_LATENCY-1:0] rd_pipe;

  // Next-state and acceptance decode for capture and readout requests
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    wr_acc     = 1'b0;
    at_last    = (o_wr_ptr == LAST_ADDR);
    rd_acc     = i_rd_req && (state != CAPTURE) && !o_rd_busy;
    rd_oob     = ({1'b0, i_rd_addr} >= DEPTH_WIDE);
    ram_ready  = rd_pipe[RAM_LATENCY-1];
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          start_acc  = 1'b1;
          state_next = CAPTURE;
        end else begin
          state_next = state;
        end
      end
      CAPTURE: begin
        wr_acc = i_sample_valid;
`ifdef CIRCULAR_CAPTURE_EN
        if (i_stop) begin
          state_next = DONE;
        end else begin
          state_next = CAPTURE;
        end
`else
        // One-shot: the write to the last address ends the capture on its own
        if (i_stop || (i_sample_valid && at_last)) begin
          state_next = DONE;
        end else begin
          state_next = CAPTURE;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; o_busy mirrors the CAPTURE state as a register
  always_ff @(posedge clock) begin
    if (rstb) begin
      state  <= IDLE;
      o_busy <= 1'b0;
    end else begin
      state  <= state_next;
      o_busy <= (state_next == CAPTURE);
    end
  end

  // Capture datapath: RAM write strobe, pointer, count and full flag
  always_ff @(posedge clock) begin
    if (rstb) begin
      o_ram_wr_en   <= 1'b0;
      o_ram_wr_addr <= '0;
      o_ram_wr_data <= '0;
      o_wr_ptr      <= '0;
      o_count       <= '0;
      o_full        <= 1'b0;
    end else begin
      o_ram_wr_en <= wr_acc;
      if (wr_acc) begin
        o_ram_wr_addr <= o_wr_ptr;
        o_ram_wr_data <= i_sample;
      end else begin
        o_ram_wr_addr <= o_ram_wr_addr;
        o_ram_wr_data <= o_ram_wr_data;
      end
      if (start_acc) begin
        o_wr_ptr <= '0;
        o_count  <= '0;
        o_full   <= 1'b0;
      end else if (wr_acc) begin
`ifdef CIRCULAR_CAPTURE_EN
        o_wr_ptr <= at_last ? '0 : (o_wr_ptr + ADDR_WIDTH'(1));
`else
        o_wr_ptr <= o_wr_ptr + ADDR_WIDTH'(1);
`endif
        if (o_count != DEPTH_COUNT) begin
          o_count <= o_count + ADDR_WIDTH'(1);
        end else begin
          o_count <= o_count;
        end
        if (at_last) begin
          o_full <= 1'b1;
        end else begin
          o_full <= o_full;
        end
      end else begin
        o_wr_ptr <= o_wr_ptr;
        o_count  <= o_count;
        o_full   <= o_full;
      end
    end
  end

  // Readout sequencer: one-cycle RAM read strobe, latency pipeline, data capture and strobes
  always_ff @(posedge clock) begin
    if (rstb) begin
      o_ram_rd_en   <= 1'b0;
      o_ram_rd_addr <= '0;
      rd_pipe       <= '0;
      o_rd_data     <= '0;
      o_rd_valid    <= 1'b0;
      o_rd_err      <= 1'b0;
      o_rd_busy     <= 1'b0;
    end else begin
      o_ram_rd_en <= rd_acc && !rd_oob;
      if (rd_acc && !rd_oob) begin
        o_ram_rd_addr <= i_rd_addr;
      end else begin
        o_ram_rd_addr <= o_ram_rd_addr;
      end
      // The MSB of the pipe marks the cycle in which RAM data is valid
      rd_pipe    <= RAM_LATENCY'({rd_pipe, o_ram_rd_en});
      o_rd_valid <= 1'b0;
      o_rd_err   <= 1'b0;
      if (rd_acc && rd_oob) begin
        o_rd_valid <= 1'b1;
        o_rd_err   <= 1'b1;
        o_rd_data  <= '0;
        o_rd_busy  <= 1'b0;
      end else if (rd_acc) begin
        o_rd_busy  <= 1'b1;
      end else if (ram_ready) begin
        o_rd_valid <= 1'b1;
        o_rd_data  <= i_ram_rd_data;
        o_rd_busy  <= 1'b0;
      end else begin
        o_rd_data  <= o_rd_data;
        o_rd_busy  <= o_rd_busy;
      end
    end
  end

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl: two instances (RAM latency 1 and 2) share stimulus.
// A reference model predicts RAM writes, readout responses and status; monitors compare.
module tb_bram_capture_ctrl;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int AW = 4;
`ifdef CIRCULAR_CAPTURE_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rstb, start, stop, sv, rq;
  logic [DW-1:0] smp;
  logic [AW-1:0] ra;

  logic [DW-1:0] rd0, rd1, wd0, wd1, rdat0, rdat1, mid1;
  logic          rv0, rv1, re0, re1, rb0, rb1, bz0, bz1, fu0, fu1;
  logic          we0, we1, ren0, ren1;
  logic [AW-1:0] cn0, cn1, wp0, wp1, wa0, wa1, raa0, raa1;

  bram_capture_ctrl #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .RAM_LATENCY(1)) u_lat1 (
    .clock(clock), .rstb(rstb), .i_start(start), .i_stop(stop), .i_sample_valid(sv),
    .i_sample(smp), .i_rd_req(rq), .i_rd_addr(ra), .o_rd_data(rd0), .o_rd_valid(rv0),
    .o_rd_err(re0), .o_rd_busy(rb0), .o_busy(bz0), .o_full(fu0), .o_count(cn0),
    .o_wr_ptr(wp0), .o_ram_wr_en(we0), .o_ram_wr_addr(wa0), .o_ram_wr_data(wd0),
    .o_ram_rd_en(ren0), .o_ram_rd_addr(raa0), .i_ram_rd_data(rdat0));

  bram_capture_ctrl #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .RAM_LATENCY(2)) u_lat2 (
    .clock(clock), .rstb(rstb), .i_start(start), .i_stop(stop), .i_sample_valid(sv),
    .i_sample(smp), .i_rd_req(rq), .i_rd_addr(ra), .o_rd_data(rd1), .o_rd_valid(rv1),
    .o_rd_err(re1), .o_rd_busy(rb1), .o_busy(bz1), .o_full(fu1), .o_count(cn1),
    .o_wr_ptr(wp1), .o_ram_wr_en(we1), .o_ram_wr_addr(wa1), .o_ram_wr_data(wd1),
    .o_ram_rd_en(ren1), .o_ram_rd_addr(raa1), .i_ram_rd_data(rdat1));

  // Edge counter: after posedge n, cyc == n
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Block RAM models: latency 1 for u_lat1, latency 2 for u_lat2
  logic [DW-1:0] ram0 [16];
  logic [DW-1:0] ram1 [16];
  always @(posedge clock) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) begin
        ram0[i] <= '0;
        ram1[i] <= '0;
      end
    end else begin
      if (we0) ram0[wa0] <= wd0;
      if (we1) ram1[wa1] <= wd1;
    end
    if (ren0) rdat0 <= ram0[raa0];
    if (ren1) mid1 <= ram1[raa1];
    rdat1 <= mid1;
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Reference model: capture state, counters, RAM picture, readout timing
  typedef struct { int c; logic [31:0] a; logic [31:0] d; } wexp_t;
  typedef struct { int c; logic [31:0] d; bit err; } rexp_t;
  wexp_t wq[$];
  rexp_t rq0[$];
  rexp_t rq1[$];

  int          mst = 0;          // 0 idle, 1 capturing, 2 done
  int          mcnt = 0, mptr = 0;
  bit          mfull = 1'b0;
  logic [31:0] mmem [16];
  int          rd_edge [2] = '{-100, -100};

  function automatic int lat(int k);
    return k + 1;
  endfunction

  function automatic void model_read(int k, int e, int a);
    rexp_t r;
    if (e < rd_edge[k] + lat(k) + 2) return;      // still busy with the previous read
    if (a >= D) begin
      r = '{e, 32'd0, 1'b1};
    end else begin
      r = '{e + lat(k) + 1, mmem[a], 1'b0};
      rd_edge[k] = e;
    end
    if (k == 0) rq0.push_back(r); else rq1.push_back(r);
  endfunction

  task automatic step(input bit st, input bit sp, input bit v, input logic [31:0] s,
                      input bit r, input int a, input bit rs);
    int e;
    rstb = rs; start = st; stop = sp; sv = v; smp = s; rq = r; ra = AW'(a);
    e = cyc + 1;
    if (rs) begin
      mst = 0; mcnt = 0; mptr = 0; mfull = 1'b0;
      rd_edge[0] = -100; rd_edge[1] = -100;
      while (wq.size() > 0 && wq[$].c >= e) void'(wq.pop_back());
      while (rq0.size() > 0 && rq0[$].c >= e) void'(rq0.pop_back());
      while (rq1.size() > 0 && rq1[$].c >= e) void'(rq1.pop_back());
    end else begin
      if (r && mst != 1) begin
        model_read(0, e, a);
        model_read(1, e, a);
      end
      if (mst != 1 && st) begin
        mst = 1; mcnt = 0; mptr = 0; mfull = 1'b0;
      end else if (mst == 1) begin
        if (v) begin
          wq.push_back('{e, 32'(mptr), s});
          mmem[mptr] = s;
          if (mptr == D - 1) begin
            mfull = 1'b1;
            if (!CIRC) mst = 2;
          end
          mptr = CIRC ? (mptr + 1) % D : mptr + 1;
          if (mcnt < D) mcnt++;
        end
        if (sp) mst = 2;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 0, 0, 0);
  endtask

  task automatic rd(int a);
    step(0, 0, 0, 32'd0, 1, a, 0);
    idle(4);
  endtask

  task automatic chk_status(string tag);
    chk({tag, ".busy1"},   32'(bz0), 32'(mst == 1));
    chk({tag, ".busy2"},   32'(bz1), 32'(mst == 1));
    chk({tag, ".full1"},   32'(fu0), 32'(mfull));
    chk({tag, ".full2"},   32'(fu1), 32'(mfull));
    chk({tag, ".count1"},  32'(cn0), 32'(mcnt));
    chk({tag, ".count2"},  32'(cn1), 32'(mcnt));
    chk({tag, ".wrptr1"},  32'(wp0), 32'(mptr % 16));
    chk({tag, ".wrptr2"},  32'(wp1), 32'(mptr % 16));
    chk({tag, ".rdbusy1"}, 32'(rb0), 32'(cyc >= rd_edge[0] && cyc <= rd_edge[0] + 1));
    chk({tag, ".rdbusy2"}, 32'(rb1), 32'(cyc >= rd_edge[1] && cyc <= rd_edge[1] + 2));
  endtask

  // Monitor: RAM write strobes against the write scoreboard
  always @(negedge clock) begin
    if (we0 || we1 || (wq.size() > 0 && wq[0].c == cyc)) begin
      if (wq.size() > 0 && wq[0].c == cyc) begin
        chk("wr_en1", 32'(we0), 32'd1);
        chk("wr_en2", 32'(we1), 32'd1);
        chk("wr_addr1", 32'(wa0), wq[0].a);
        chk("wr_addr2", 32'(wa1), wq[0].a);
        chk("wr_data1", wd0, wq[0].d);
        chk("wr_data2", wd1, wq[0].d);
        void'(wq.pop_front());
      end else begin
        chk("wr_spurious1", 32'(we0), 32'd0);
        chk("wr_spurious2", 32'(we1), 32'd0);
      end
    end
  end

  // Monitor: readout strobes against the per-instance read scoreboards
  always @(negedge clock) begin
    if (rq0.size() > 0 && rq0[0].c == cyc) begin
      chk("rd_valid1", 32'(rv0), 32'd1);
      chk("rd_data1", rd0, rq0[0].d);
      chk("rd_err1", 32'(re0), 32'(rq0[0].err));
      void'(rq0.pop_front());
    end else if (rv0 || re0) begin
      chk("rd_spurious1", 32'(rv0 | re0), 32'd0);
    end
    if (rq1.size() > 0 && rq1[0].c == cyc) begin
      chk("rd_valid2", 32'(rv1), 32'd1);
      chk("rd_data2", rd1, rq1[0].d);
      chk("rd_err2", 32'(re1), 32'(rq1[0].err));
      void'(rq1.pop_front());
    end else if (rv1 || re1) begin
      chk("rd_spurious2", 32'(rv1 | re1), 32'd0);
    end
  end

  initial begin
    rstb = 1'b1; start = 1'b0; stop = 1'b0; sv = 1'b0; smp = '0; rq = 1'b0; ra = '0;
    for (int i = 0; i < 16; i++) mmem[i] = 32'd0;
    @(negedge clock);
    step(0, 0, 0, 32'd0, 0, 0, 1);
    step(0, 0, 0, 32'd0, 0, 0, 1);
    step(0, 0, 0, 32'd0, 0, 0, 0);

    // Reset state: every output zero
    chk("rst.rd_data", rd0 | rd1, 32'd0);
    chk("rst.strobes", 32'({rv0, rv1, re0, re1, rb0, rb1, we0, we1, ren0, ren1}), 32'd0);
    chk("rst.ram_addr", 32'({wa0, wa1, raa0, raa1}), 32'd0);
    chk("rst.wr_data", wd0 | wd1, 32'd0);
    chk_status("rst");

    // Read address 0 from IDLE
    rd(0);

    // Capture five samples then stop
    step(1, 0, 0, 32'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hA0 + 32'(i), 0, 0, 0);
    step(0, 1, 0, 32'd0, 0, 0, 0);
    idle(1);
    chk_status("cap5");

    // Readout in DONE, a request while busy, and an out-of-range address
    rd(3);
    for (int i = 0; i < 5; i++) rd(i);
    step(0, 0, 0, 32'd0, 1, 1, 0);
    step(0, 0, 0, 32'd0, 1, 4, 0);
    chk_status("rdbusy");
    idle(4);
    rd(D);
    rd(D + 3);

    // Fill capture: nine consecutive samples, the ninth lands after full
    step(1, 0, 0, 32'd0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 32'hB0 + 32'(i), 0, 0, 0);
    chk_status("full");
    step(0, 1, 0, 32'd0, 0, 0, 0);
    idle(1);
    chk_status("fullstop");
    rd(0);
    rd(D - 1);

    // Reset mid-capture, then a short recapture
    step(1, 0, 0, 32'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hC0 + 32'(i), 0, 0, 0);
    step(0, 0, 1, 32'hC3, 0, 0, 1);
    chk_status("midrst");
    step(0, 0, 1, 32'hC4, 0, 0, 0);
    step(1, 0, 0, 32'd0, 0, 0, 0);
    step(0, 0, 1, 32'hD0, 0, 0, 0);
    step(0, 0, 1, 32'hD1, 0, 0, 0);
    step(0, 1, 0, 32'd0, 0, 0, 0);
    chk_status("recap");
    rd(0);
    rd(1);
    rd(2);

`ifdef CIRCULAR_CAPTURE_EN
    // Circular: eleven samples wrap the pointer to 3
    step(1, 0, 0, 32'd0, 0, 0, 0);
    for (int i = 1; i <= 11; i++) step(0, 0, 1, 32'hE0 + 32'(i), 0, 0, 0);
    step(0, 1, 0, 32'd0, 0, 0, 0);
    chk_status("circ");
    for (int i = 0; i < 4; i++) rd(i);
`endif

    // Randomized traffic including resets and concurrent requests
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(99, 0) < 6, $urandom_range(99, 0) < 4, $urandom_range(1, 0) == 1,
           $urandom, $urandom_range(99, 0) < 25, $urandom_range(D + 1, 0),
           $urandom_range(199, 0) == 0);
      chk_status("rand");
    end
    step(0, 1, 0, 32'd0, 0, 0, 0);
    idle(6);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq1_drained", 32'(rq0.size()), 32'd0);
    chk("rq2_drained", 32'(rq1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
